// File: rtl/median_pkg.sv
// Shared types and constants for the 3x3 median-of-medians controller.
// Optional frame counter is enabled by MEDIAN9_CTRL_FRAME_CNT_EN.
package median_pkg;

  typedef enum logic [2:0] {
    LOAD,
    ROW0,
    ROW1,
    ROW2,
    FINAL,
    OUT
  } state_e;

  localparam int FRAME_LEN = 9;
  localparam int ROW_LEN   = 3;

  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

endpackage

// File: rtl/median3_core.sv
// Combinational 3-input unsigned median.
// Shared by all four passes of median9_ctrl.
module median3_core #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] med
);

  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] hi_c;

  always_comb begin
    lo   = (a < b) ? a : b;
    hi   = (a < b) ? b : a;
    hi_c = (hi < c) ? hi : c;
    med  = (lo > hi_c) ? lo : hi_c;
  end

endmodule

// File: rtl/median9_ctrl.sv
// Streaming 3x3 median-of-medians controller, one median unit time-shared.
// Define MEDIAN9_CTRL_FRAME_CNT_EN to add the saturating frame_cnt port.
module median9_ctrl
  import median_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
`ifdef MEDIAN9_CTRL_FRAME_CNT_EN
  ,
  output logic [7:0]        frame_cnt
`endif
);

  state_e state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [DATA_W-1:0] s_q [FRAME_LEN];
  logic [DATA_W-1:0] m_q [ROW_LEN];
  logic [DATA_W-1:0] out_q;

  logic [DATA_W-1:0] ma, mb, mc, med;

  median3_core #(
    .DATA_W(DATA_W)
  ) u_med (
    .a  (ma),
    .b  (mb),
    .c  (mc),
    .med(med)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    ma        = s_q[0];
    mb        = s_q[1];
    mc        = s_q[2];
    unique case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = 4'd0;
            state_d = ROW0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ROW0: state_d = ROW1;
      ROW1: begin
        ma      = s_q[ROW_LEN];
        mb      = s_q[ROW_LEN+1];
        mc      = s_q[ROW_LEN+2];
        state_d = ROW2;
      end
      ROW2: begin
        ma      = s_q[2*ROW_LEN];
        mb      = s_q[2*ROW_LEN+1];
        mc      = s_q[2*ROW_LEN+2];
        state_d = FINAL;
      end
      FINAL: begin
        ma      = m_q[0];
        mb      = m_q[1];
        mc      = m_q[2];
        state_d = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      idx_q   <= 4'd0;
      out_q   <= '0;
      for (int i = 0; i < FRAME_LEN; i++) s_q[i] <= '0;
      for (int i = 0; i < ROW_LEN; i++) m_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == LOAD && in_valid) s_q[idx_q] <= in_data;
      if (state_q == ROW0) m_q[0] <= med;
      if (state_q == ROW1) m_q[1] <= med;
      if (state_q == ROW2) m_q[2] <= med;
      if (state_q == FINAL) out_q <= med;
    end
  end

  assign out_data = out_q;
  assign busy     = (state_q != LOAD) || (idx_q != 4'd0);

`ifdef MEDIAN9_CTRL_FRAME_CNT_EN
  logic [7:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    if (out_valid && out_ready && fcnt_q != 8'hFF) fcnt_d = fcnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fcnt_q <= 8'd0;
    else     fcnt_q <= fcnt_d;
  end

  assign frame_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_median9_ctrl.sv
// Self-checking bench for median9_ctrl with a sort-based reference model.
// Frame counter checks are active when MEDIAN9_CTRL_FRAME_CNT_EN is defined.
module tb_median9_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;
`ifdef MEDIAN9_CTRL_FRAME_CNT_EN
  logic [7:0]   frame_cnt;
  int           fc_exp = 0;
`endif

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  median9_ctrl #(
    .DATA_W(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
`ifdef MEDIAN9_CTRL_FRAME_CNT_EN
    ,
    .frame_cnt(frame_cnt)
`endif
  );

  function automatic logic [W-1:0] med3(input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    int v [3];
    int t;
    v[0] = int'(a);
    v[1] = int'(b);
    v[2] = int'(c);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2 - i; j++)
        if (v[j] > v[j+1]) begin
          t      = v[j];
          v[j]   = v[j+1];
          v[j+1] = t;
        end
    return W'(v[1]);
  endfunction

  function automatic logic [W-1:0] mom(input logic [W-1:0] s [9]);
    return med3(med3(s[0], s[1], s[2]),
                med3(s[3], s[4], s[5]),
                med3(s[6], s[7], s[8]));
  endfunction

  task automatic load_frame(input logic [W-1:0] smp [9], input bit gaps);
    int i = 0;
    int t = 0;
    bit hs;
    bit tog = 1'b1;
    while (i < 9) begin
      in_valid = gaps ? tog : 1'b1;
      tog      = ~tog;
      in_data  = smp[i];
      hs       = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) i++;
      t++;
      if (i > 0 && i < 9) begin
        nvec++;
        if (busy !== 1'b1) begin
          nbad++;
          $display("FAIL busy_load got=%b want=1 idx=%0d", busy, i);
        end
      end
      if (t > 100) begin
        nvec++;
        nbad++;
        $display("FAIL load_timeout accepted=%0d want=9", i);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_frame(input logic [W-1:0] exp, input int hold,
                              input bit early);
    logic [W-1:0] held;
    out_ready = early;
    for (int k = 0; k < 4; k++) begin
      nvec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
        nbad++;
        $display("FAIL latency_%0d got ov=%b ir=%b bz=%b want ov=0 ir=0 bz=1",
                 k, out_valid, in_ready, busy);
      end
      if (k < 3) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    nvec++;
    if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
      nbad++;
      $display("FAIL result got ov=%b data=%0d ir=%b want ov=1 data=%0d ir=0",
               out_valid, out_data, in_ready, exp);
    end
    held = out_data;
    if (!early) begin
      for (int k = 0; k < hold; k++) begin
        @(posedge clk);
        #1;
        nvec++;
        if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
          nbad++;
          $display("FAIL hold_%0d got ov=%b data=%0d ir=%b want ov=1 data=%0d ir=0",
                   k, out_valid, out_data, in_ready, held);
        end
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    nvec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      nbad++;
      $display("FAIL after_out got ir=%b ov=%b bz=%b want ir=1 ov=0 bz=0",
               in_ready, out_valid, busy);
    end
`ifdef MEDIAN9_CTRL_FRAME_CNT_EN
    fc_exp = (fc_exp >= 255) ? 255 : fc_exp + 1;
    nvec++;
    if (frame_cnt !== 8'(fc_exp)) begin
      nbad++;
      $display("FAIL frame_cnt got=%0d want=%0d", frame_cnt, fc_exp);
    end
`endif
  endtask

  task automatic run_frame(input logic [W-1:0] smp [9], input bit gaps,
                           input int hold, input bit early);
    load_frame(smp, gaps);
    finish_frame(mom(smp), hold, early);
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
`ifdef MEDIAN9_CTRL_FRAME_CNT_EN
    fc_exp = 0;
    nvec++;
    if (frame_cnt !== 8'd0) begin
      nbad++;
      $display("FAIL reset_fcnt got=%0d want=0", frame_cnt);
    end
`endif
    @(posedge clk);
    #1;
    nvec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0) begin
      nbad++;
      $display("FAIL reset got ir=%b ov=%b data=%0d bz=%b want ir=1 ov=0 data=0 bz=0",
               in_ready, out_valid, out_data, busy);
    end
  endtask

  task automatic test_ascending;
    logic [W-1:0] f [9];
    for (int i = 0; i < 9; i++) f[i] = W'(i + 1);
    nvec++;
    if (mom(f) !== 4'd5) begin
      nbad++;
      $display("FAIL model_asc got=%0d want=5", mom(f));
    end
    run_frame(f, 1'b0, 0, 1'b1);
  endtask

  task automatic test_extremes;
    logic [W-1:0] f [9];
    f = '{4'd9, 4'd0, 4'd4, 4'd15, 4'd15, 4'd0, 4'd3, 4'd3, 4'd3};
    run_frame(f, 1'b0, 0, 1'b0);
  endtask

  task automatic test_backpressure;
    logic [W-1:0] f [9];
    for (int i = 0; i < 9; i++) f[i] = W'(8 - i);
    run_frame(f, 1'b0, 10, 1'b0);
  endtask

  task automatic test_gaps;
    logic [W-1:0] f [9];
    f = '{4'd7, 4'd7, 4'd7, 4'd0, 4'd0, 4'd0, 4'd15, 4'd15, 4'd15};
    run_frame(f, 1'b1, 1, 1'b0);
  endtask

  task automatic test_abort;
    logic [W-1:0] f [9];
    for (int i = 0; i < 9; i++) f[i] = W'(15 - i);
    load_frame(f, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    nvec++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      nbad++;
      $display("FAIL abort got ov=%b bz=%b ir=%b want ov=0 bz=0 ir=1",
               out_valid, busy, in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
`ifdef MEDIAN9_CTRL_FRAME_CNT_EN
    fc_exp = 0;
`endif
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      nvec++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        nbad++;
        $display("FAIL abort_quiet_%0d got ov=%b bz=%b want ov=0 bz=0",
                 k, out_valid, busy);
      end
    end
    for (int i = 0; i < 9; i++) f[i] = W'(i + 1);
    run_frame(f, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random;
    logic [W-1:0] f [9];
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 9; i++) f[i] = W'($urandom_range(0, 15));
      run_frame(f, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
    end
  endtask

`ifdef MEDIAN9_CTRL_FRAME_CNT_EN
  task automatic test_frame_cnt_sat;
    logic [W-1:0] f [9];
    for (int n = 0; n < 260; n++) begin
      for (int i = 0; i < 9; i++) f[i] = W'($urandom_range(0, 15));
      run_frame(f, 1'b0, 0, 1'b1);
    end
    nvec++;
    if (frame_cnt !== 8'd255) begin
      nbad++;
      $display("FAIL frame_cnt_sat got=%0d want=255", frame_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ascending();
    test_extremes();
    test_backpressure();
    test_gaps();
    test_abort();
    test_random();
`ifdef MEDIAN9_CTRL_FRAME_CNT_EN
    test_frame_cnt_sat();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/median9_ctrl.md
# median9_ctrl

Streaming 3x3 median-of-medians controller. It collects nine DATA_W-bit samples over a valid/ready input stream and time-multiplexes one 3-input median unit across four passes: three row medians, then the median of those. It returns one result per frame on a valid/ready output stream. It sits between a sample source, such as a pixel window fetcher, and a result consumer, and it is the only sequencer of the median datapath.

## Interface
Parameters:
- DATA_W, 4, sample and result width in bits.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  DATA_W  sample, unsigned.
- out_valid  output  1  out_data holds a frame result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_data  output  DATA_W  median-of-medians result, unsigned.
- busy  output  1  frame in progress: at least one sample held, or result not yet taken.

## Operation
States:
- LOAD (reset state)
- ROW0, ROW1, ROW2
- FINAL
- OUT

State behaviour:
- LOAD
  - in_ready=1.
  - Each in_valid&&in_ready handshake stores in_data into s[idx], row-major s0..s8, then idx+1.
  - A 4-bit idx counts 0..8.
  - On the handshake with idx==8: go to ROW0, clear idx to 0.
- ROWr (r=0,1,2)
  - Drive the median unit with s[3r], s[3r+1], s[3r+2].
  - Register the result into m[r].
  - Advance one state per cycle, unconditionally.
- FINAL
  - Drive the median unit with m0, m1, m2.
  - Register the result into out_data; go to OUT.
- OUT
  - out_valid=1; out_data is held stable.
  - On out_ready: go to LOAD.
- in_ready=0 in every state except LOAD. Input samples are never dropped or overwritten.

Arithmetic:
- Comparisons are unsigned DATA_W-bit compares.
- Median of equal values returns that value; ties need no special handling.

Outputs:
- busy = (state!=LOAD) || (idx!=0).
- Output reset values: in_ready=1, out_valid=0, out_data=0, busy=0.
- Reset also clears idx, state, s[], m[].

Boundary conditions:
- Reset asserted mid-frame, in any state: the partial frame is discarded, with no output for it.
- Input handshake while in OUT: impossible, because in_ready=0.
- in_valid gaps during LOAD: idx holds; no timeout.
- out_ready high before out_valid: ignored.

## Timing
- in_ready and out_valid are decoded directly from state, not combinationally from in_valid or out_ready.
- Latency: call the edge that accepts s8 edge E. The block is in ROW0 in the cycle after E. out_valid rises after edge E+4, i.e. 4 cycles in ROW0..FINAL.
- Output handshake on edge F: in_ready=1 in the cycle after F. The next s0 can be accepted at edge F+1.
- Minimum frame period: 9 load cycles + 4 compute cycles + 1 output cycle = 14 cycles.

## Configuration
- MEDIAN9_CTRL_FRAME_CNT_EN defined:
  - Adds output port frame_cnt, 8 bits.
  - Reset value 0.
  - Increments on each out_valid&&out_ready handshake.
  - Saturates at 255.
- MEDIAN9_CTRL_FRAME_CNT_EN undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Shared package median_pkg holds:
  - state enum {LOAD, ROW0, ROW1, ROW2, FINAL, OUT};
  - constants FRAME_LEN=9 and ROW_LEN=3.
- One sub-module: median3_core, combinational, DATA_W-parameterized 3-input median. It is instantiated exactly once; its three inputs are muxed by state.

## Test plan
- Samples 1,2,3,4,5,6,7,8,9 with in_valid held high, out_ready high -> row medians 2,5,8; out_data=5; out_valid rises 4 cycles after the s8 handshake.
- Samples 9,0,4,15,15,0,3,3,3 -> row medians 4,15,3; out_data=4.
- out_ready held low 10 cycles after out_valid -> out_valid=1, out_data constant, in_ready=0 throughout. Raising out_ready -> in_ready=1 the next cycle.
- in_valid toggling 1/0 every cycle for frame 7,7,7,0,0,0,15,15,15 -> idx advances only on handshakes; out_data=7.
- rst pulsed while in ROW1, then a fresh frame 1..9 -> no output from the aborted frame; next out_data=5.
- With MEDIAN9_CTRL_FRAME_CNT_EN: 260 back-to-back frames -> frame_cnt reaches 255 and stays at 255.
